// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: single-transaction CPU-to-memory bus controller with timeout.
// Ports:
//   clk, rst (async active-low)         clock and reset
//   R, W, addr, wdata                   CPU request levels, address and write data
//   Wait, Done, rdata, err              CPU-side status, read data and error pulse
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_ack, mem_rdata       memory-side handshake and data
module mem_bus_ctrl #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          R,
    input  logic          W,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          Wait,
    output logic          Done,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] cnt;
    logic       err_q;
    logic       start, timed_out;

    assign start     = (state == IDLE) && (R ^ W);
    // an ack on the final count wins over the timeout
    assign timed_out = (state == BUSY) && !mem_ack && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        Wait      = 1'b0;
        Done      = 1'b0;
        mem_req   = 1'b0;
        err       = err_q;
        case (state)
            IDLE: state_nxt = start ? BUSY : IDLE;
            BUSY: begin
                Wait      = 1'b1;
                mem_req   = 1'b1;
                state_nxt = (mem_ack || cnt == LAST) ? DONE : BUSY;
            end
            default: begin
                Done      = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            err_q     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
        end else begin
            // illegal request flags the following IDLE cycle; timeout flags the DONE cycle
            err_q <= ((state == IDLE) && R && W) || timed_out;
            if (start) begin
                mem_addr  <= addr;
                mem_wdata <= wdata;
                mem_we    <= W;
                cnt       <= '0;
            end else if (state == BUSY && !mem_ack) begin
                cnt <= cnt + 8'd1;
            end
            if (state == BUSY && mem_ack && !mem_we) rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed self-checking bench for mem_bus_ctrl.
module tb_mem_bus_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        R, W;
    logic [31:0] addr, wdata;
    logic        Wait, Done, err;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    mem_bus_ctrl #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .R(R), .W(W), .addr(addr), .wdata(wdata),
        .Wait(Wait), .Done(Done), .rdata(rdata), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; R = 0; W = 0; addr = 0; wdata = 0; mem_ack = 0; mem_rdata = 0;
        tick(); tick();
        vectors++; if ({Wait, Done, err, mem_req, mem_we} !== 5'b0) begin miscompares++; $display("FAIL reset_ctrl: got %b want 00000", {Wait, Done, err, mem_req, mem_we}); end
        vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
        vectors++; if (mem_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
        vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        rst = 1'b1;
        tick();
        vectors++; if ({Wait, Done, err, mem_req} !== 4'b0) begin miscompares++; $display("FAIL reset_idle: got %b want 0000", {Wait, Done, err, mem_req}); end
    endtask

    task automatic test_read();
        R = 1; addr = 32'h100;
        tick();
        R = 0;
        for (int i = 0; i < 3; i++) begin
            vectors++; if ({Wait, mem_req, mem_we, Done} !== 4'b1100) begin miscompares++; $display("FAIL read_busy%0d: got %b want 1100", i, {Wait, mem_req, mem_we, Done}); end
            vectors++; if (mem_addr !== 32'h100) begin miscompares++; $display("FAIL read_addr%0d: got %h want 100", i, mem_addr); end
            if (i == 0) begin W = 1; addr = 32'hFFF; end
            if (i == 1) W = 0;
            if (i == 2) begin mem_ack = 1; mem_rdata = 32'hDEADBEEF; end
            tick();
        end
        mem_ack = 0;
        vectors++; if ({Done, Wait, mem_req, err} !== 4'b1000) begin miscompares++; $display("FAIL read_done: got %b want 1000", {Done, Wait, mem_req, err}); end
        vectors++; if (rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL read_rdata: got %h want deadbeef", rdata); end
        tick();
        vectors++; if ({Done, Wait, err} !== 3'b000) begin miscompares++; $display("FAIL read_after: got %b want 000", {Done, Wait, err}); end
    endtask

    task automatic test_write();
        mem_ack = 1; mem_rdata = 32'h55555555;
        tick();
        vectors++; if ({Wait, Done, mem_req} !== 3'b000) begin miscompares++; $display("FAIL ack_idle: got %b want 000", {Wait, Done, mem_req}); end
        W = 1; addr = 32'h20; wdata = 32'h12345678;
        tick();
        W = 0;
        vectors++; if ({Wait, mem_req, mem_we} !== 3'b111) begin miscompares++; $display("FAIL write_busy: got %b want 111", {Wait, mem_req, mem_we}); end
        vectors++; if (mem_wdata !== 32'h12345678) begin miscompares++; $display("FAIL write_wdata: got %h want 12345678", mem_wdata); end
        vectors++; if (mem_addr !== 32'h20) begin miscompares++; $display("FAIL write_addr: got %h want 20", mem_addr); end
        tick();
        mem_ack = 0;
        vectors++; if ({Done, Wait, err} !== 3'b100) begin miscompares++; $display("FAIL write_done: got %b want 100", {Done, Wait, err}); end
        vectors++; if (rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL write_rdata: got %h want deadbeef", rdata); end
        tick();
    endtask

    task automatic test_timeout();
        int n = 0;
        R = 1; addr = 32'h300;
        tick();
        R = 0; mem_rdata = 32'hAAAA0000;
        while (Wait && n < 40) begin
            n++;
            vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL timeout_err_busy%0d: got %b want 0", n, err); end
            tick();
        end
        vectors++; if (n !== 16) begin miscompares++; $display("FAIL timeout_cycles: got %0d want 16", n); end
        vectors++; if ({Done, err} !== 2'b11) begin miscompares++; $display("FAIL timeout_done: got %b want 11", {Done, err}); end
        vectors++; if (rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL timeout_rdata: got %h want deadbeef", rdata); end
        tick();
        vectors++; if ({Done, err, Wait} !== 3'b000) begin miscompares++; $display("FAIL timeout_after: got %b want 000", {Done, err, Wait}); end
    endtask

    task automatic test_illegal();
        R = 1; W = 1;
        tick();
        R = 0; W = 0;
        vectors++; if ({err, mem_req, Wait, Done} !== 4'b1000) begin miscompares++; $display("FAIL illegal_pulse: got %b want 1000", {err, mem_req, Wait, Done}); end
        tick();
        vectors++; if ({err, mem_req, Wait, Done} !== 4'b0000) begin miscompares++; $display("FAIL illegal_after: got %b want 0000", {err, mem_req, Wait, Done}); end
    endtask

    task automatic test_ack_on_timeout();
        R = 1; addr = 32'h400;
        tick();
        R = 0;
        for (int i = 0; i < 15; i++) tick();
        vectors++; if (Wait !== 1'b1) begin miscompares++; $display("FAIL acktmo_busy: got %b want 1", Wait); end
        mem_ack = 1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 0;
        vectors++; if ({Done, err} !== 2'b10) begin miscompares++; $display("FAIL acktmo_done: got %b want 10", {Done, err}); end
        vectors++; if (rdata !== 32'hCAFEF00D) begin miscompares++; $display("FAIL acktmo_rdata: got %h want cafef00d", rdata); end
        tick();
    endtask

    task automatic test_reset_mid_busy();
        R = 1; addr = 32'h40;
        tick();
        R = 0;
        tick();
        rst = 0;
        #1;
        vectors++; if ({Wait, mem_req, Done} !== 3'b000) begin miscompares++; $display("FAIL rstbusy_drop: got %b want 000", {Wait, mem_req, Done}); end
        vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL rstbusy_addr: got %h want 0", mem_addr); end
        tick();
        vectors++; if ({Done, Wait} !== 2'b00) begin miscompares++; $display("FAIL rstbusy_nodone: got %b want 00", {Done, Wait}); end
        rst = 1; R = 1; addr = 32'h80;
        tick();
        R = 0; mem_ack = 1; mem_rdata = 32'h0BADF00D;
        vectors++; if ({Wait, mem_addr} !== {1'b1, 32'h80}) begin miscompares++; $display("FAIL rstbusy_newreq: got %b/%h want 1/80", Wait, mem_addr); end
        tick();
        mem_ack = 0;
        vectors++; if ({Done, rdata} !== {1'b1, 32'h0BADF00D}) begin miscompares++; $display("FAIL rstbusy_done: got %b/%h want 1/0badf00d", Done, rdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        R = 1; addr = 32'h500; mem_ack = 1; mem_rdata = 32'h11112222;
        tick();
        vectors++; if (Wait !== 1'b1) begin miscompares++; $display("FAIL b2b_busy1: got %b want 1", Wait); end
        tick();
        vectors++; if ({Done, rdata} !== {1'b1, 32'h11112222}) begin miscompares++; $display("FAIL b2b_done1: got %b/%h want 1/11112222", Done, rdata); end
        mem_rdata = 32'h33334444;
        tick();
        vectors++; if ({Wait, Done} !== 2'b00) begin miscompares++; $display("FAIL b2b_idle: got %b want 00", {Wait, Done}); end
        tick();
        R = 0;
        vectors++; if (Wait !== 1'b1) begin miscompares++; $display("FAIL b2b_busy2: got %b want 1", Wait); end
        tick();
        mem_ack = 0;
        vectors++; if ({Done, rdata} !== {1'b1, 32'h33334444}) begin miscompares++; $display("FAIL b2b_done2: got %b/%h want 1/33334444", Done, rdata); end
        tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_illegal();
        test_ack_on_timeout();
        test_reset_mid_busy();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameter AW, default 32, address width in bits.
REQ-002 Parameter DW, default 32, data width in bits.
REQ-003 Parameter TIMEOUT, default 16, maximum BUSY cycles allowed before abort; legal range 2..255.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 R  in  1  read request level from the clocking logic.
REQ-007 W  in  1  write request level from the clocking logic.
REQ-008 addr  in  AW  CPU address, sampled at request acceptance.
REQ-009 wdata  in  DW  CPU write data, sampled at request acceptance.
REQ-010 Wait  out  1  transaction pending; drives the clocking logic Wait input.
REQ-011 Done  out  1  one-cycle completion pulse; drives the clocking logic Done input.
REQ-012 rdata  out  DW  registered read data (MD).
REQ-013 err  out  1  one-cycle error pulse (illegal request or timeout).
REQ-014 mem_req  out  1  memory request strobe.
REQ-015 mem_we  out  1  memory write enable (1 = write, 0 = read).
REQ-016 mem_addr  out  AW  latched address.
REQ-017 mem_wdata  out  DW  latched write data.
REQ-018 mem_ack  in  1  memory acknowledge, valid only while mem_req = 1.
REQ-019 mem_rdata  in  DW  memory read data, valid in the mem_ack cycle.

Function
REQ-020 FSM states SHALL be IDLE, BUSY and DONE; all outputs except rdata and the latched bus fields are Moore-decoded from state plus a registered err flag.
REQ-021 IDLE: on R xor W sampled high, latch addr/wdata, set mem_we = W, clear the cycle counter, and go to BUSY.
REQ-022 IDLE with R = W = 1: no transaction starts, err pulses for exactly the next cycle, and state stays IDLE.
REQ-023 BUSY: mem_req = 1 and Wait = 1; mem_addr, mem_wdata and mem_we stay stable for the whole BUSY period.
REQ-024 BUSY with mem_ack = 1: go to DONE; for a read, rdata <= mem_rdata on the same edge; for a write, rdata holds its value.
REQ-025 BUSY without mem_ack: the counter increments; when the counter equals TIMEOUT-1, go to DONE with err set and rdata unchanged.
REQ-026 A mem_ack in the same cycle as the timeout condition counts as success: no err.
REQ-027 DONE: Done = 1, Wait = 0, mem_req = 0 for exactly one cycle, then unconditionally go to IDLE.
REQ-028 R/W seen in DONE is ignored; a level still high in the following IDLE cycle starts a new transaction.
REQ-029 Minimum latency: request sampled at edge N gives BUSY in cycle N+1; with an immediate ack, Done = 1 in cycle N+2.
REQ-030 err SHALL be high only in the DONE cycle of a timed-out transaction, or in the single cycle after an illegal request.
REQ-031 Changes on R/W/addr/wdata during BUSY SHALL have no effect.
REQ-032 mem_ack outside BUSY SHALL be ignored.

Reset
REQ-033 rst = 0 immediately forces: state IDLE, Wait = 0, Done = 0, err = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, rdata = 0, counter = 0.
REQ-034 Reset asserted mid-BUSY SHALL abort the transaction with no Done pulse; after release the block accepts a new request.
REQ-035 Reset release SHALL be synchronous to the next clk rising edge; the first request can be accepted on that edge.

Verification
REQ-036 Read, ack after 3 BUSY cycles: R = 1, addr = 0x100, mem_rdata = 0xDEADBEEF -> Wait high for 3 cycles, mem_we = 0, one Done pulse, rdata = 0xDEADBEEF, err = 0.
REQ-037 Write, immediate ack: W = 1, addr = 0x20, wdata = 0x12345678 -> mem_wdata = 0x12345678, mem_we = 1, Done at request edge + 2, rdata unchanged.
REQ-038 Timeout: R = 1, mem_ack held 0 -> exactly TIMEOUT (16) BUSY cycles, then Done = 1 and err = 1 together, rdata unchanged.
REQ-039 Illegal request: R = W = 1 in IDLE -> mem_req stays 0, err pulses for 1 cycle, no Done.
REQ-040 Reset mid-BUSY: rst = 0 during cycle 2 of BUSY -> mem_req and Wait drop immediately, no Done; a new read after release completes normally.
REQ-041 Ack on the timeout cycle: mem_ack = 1 at count TIMEOUT-1 -> Done = 1, err = 0, rdata captured.
